tcp_client_controller: RTL and testbench

//  Active-open (client) TCP connection controller. It is the initiating counterpart of the passive-open server controller.
//  - Sends SYN, completes the 3-way handshake, receives data and ACKs it in order, and closes actively or passively.
//  - Sits between the TCP header parser (rx op interface) and the TCP header writer (tx op interface).

---
 rtl/tcp_client_controller.sv | 371 +++++++++++++++++++++++++++++++++++++
 tb/tb_tcp_client_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_client_controller.sv
// Active-open TCP connection controller.
// Opens a connection with SYN, completes the three-way handshake, acknowledges
// in-order payload and tears the connection down either actively (close_i) or
// passively (peer FIN). Sits between the rx header parser and the tx header writer.
module tcp_client_controller #(
  parameter logic [15:0] LOCAL_PORT    = 16'hF719,
  parameter logic [15:0] REMOTE_PORT   = 16'd5000,
  parameter logic [31:0] ISS           = 32'h0,
  parameter logic [31:0] SYN_TIMEOUT   = 32'd1250000,
  parameter int unsigned SYN_RETRIES   = 3,
  parameter logic [31:0] TIME_WAIT_CYC = 32'd125000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        open_i,
  input  logic        close_i,
  input  logic        tcp_op_rcv_i,
  input  logic [15:0] tcp_source_port_i,
  input  logic [5:0]  tcp_flags_i,
  input  logic [31:0] tcp_seq_num_i,
  input  logic [31:0] tcp_ack_num_i,
  input  logic [15:0] tcp_data_len_i,
  output logic        tcp_op_rcv_rd_o,
  output logic [15:0] tcp_source_port_o,
  output logic [15:0] tcp_dest_port_o,
  output logic [5:0]  tcp_flags_o,
  output logic [31:0] tcp_seq_num_o,
  output logic [31:0] tcp_ack_num_o,
  output logic [3:0]  tcp_head_len_o,
  output logic [15:0] tcp_data_len_o,
  output logic        tcp_start_o,
  input  logic        tcp_write_op_end_i,
  input  logic        trnsmt_busy_i,
  output logic        rx_accept_o,
  output logic        connected_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_SYN_SENT,
    ST_ESTABLISHED,
    ST_FIN_WAIT1,
    ST_FIN_WAIT2,
    ST_LAST_ACK,
    ST_TIME_WAIT
  } state_e;

  // Flag encodings, bit order {URG,ACK,PSH,RST,SYN,FIN}
  localparam logic [5:0] FLG_SYN     = 6'h02;
  localparam logic [5:0] FLG_RST     = 6'h04;
  localparam logic [5:0] FLG_ACK     = 6'h10;
  localparam logic [5:0] FLG_FIN_ACK = 6'h11;

  localparam logic [7:0] MAX_RETRIES = 8'(SYN_RETRIES);

  state_e      state_q, state_d;
  logic [31:0] snd_nxt_q, snd_nxt_d;
  logic [31:0] rcv_nxt_q, rcv_nxt_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retries_q, retries_d;
  logic        syn_pend_q, syn_pend_d;
  logic        close_pend_q, close_pend_d;
  logic        tx_busy_q, tx_busy_d;
  logic        start_q, start_d;
  logic        rd_q, rd_d;
  logic        accept_q, accept_d;
  logic        error_q, error_d;
  logic [5:0]  flags_q, flags_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ack_q, ack_d;
  logic [3:0]  head_len_q, head_len_d;

  logic        tx_req;
  logic [5:0]  tx_flags;
  logic [31:0] tx_seq;
  logic [31:0] tx_ack;

  logic        seg;
  logic        seg_valid;
  logic        f_ack;
  logic        f_rst;
  logic        f_syn;
  logic        f_fin;
  logic        in_order;
  logic        has_len;
  logic        ack_ok;
  logic        can_tx;
  logic [31:0] rcv_adv;
  logic        unused_flags;

  // URG and PSH carry no meaning for this controller
  assign unused_flags = tcp_flags_i[5] ^ tcp_flags_i[3];

  assign seg       = tcp_op_rcv_i & rd_q;
  assign seg_valid = seg & (tcp_source_port_i == REMOTE_PORT);
  assign f_ack     = tcp_flags_i[4];
  assign f_rst     = tcp_flags_i[2];
  assign f_syn     = tcp_flags_i[1];
  assign f_fin     = tcp_flags_i[0];
  assign in_order  = (tcp_seq_num_i == rcv_nxt_q);
  assign has_len   = (tcp_data_len_i != 16'd0);
  assign ack_ok    = f_ack & (tcp_ack_num_i == snd_nxt_q);
  assign rcv_adv   = rcv_nxt_q + {16'd0, tcp_data_len_i} + {31'd0, f_fin};

  // Header pop handshake and writer-busy tracking; self-initiated sends defer to a pending pop
  always_comb begin
    rd_d      = tcp_op_rcv_i & ~rd_q & ~tx_busy_q & ~start_q & ~trnsmt_busy_i;
    tx_busy_d = tx_busy_q;
    if (start_q) begin
      tx_busy_d = 1'b1;
    end else if (tcp_write_op_end_i) begin
      tx_busy_d = 1'b0;
    end
    can_tx = ~tx_busy_q & ~start_q & ~rd_q & ~rd_d;
  end

  // Connection state machine: next state, sequence space and the segment to send
  always_comb begin
    state_d      = state_q;
    snd_nxt_d    = snd_nxt_q;
    rcv_nxt_d    = rcv_nxt_q;
    timer_d      = timer_q;
    retries_d    = retries_q;
    syn_pend_d   = syn_pend_q;
    accept_d     = 1'b0;
    error_d      = 1'b0;
    tx_req       = 1'b0;
    tx_flags     = FLG_ACK;
    tx_seq       = snd_nxt_q;
    tx_ack       = rcv_nxt_q;
    close_pend_d = 1'b0;

    case (state_q)
      ST_CLOSED: begin
        timer_d    = 32'd0;
        retries_d  = 8'd0;
        syn_pend_d = 1'b0;
        if (open_i) begin
          state_d   = ST_SYN_SENT;
          snd_nxt_d = ISS + 32'd1;
          rcv_nxt_d = 32'd0;
          if (can_tx) begin
            tx_req   = 1'b1;
            tx_flags = FLG_SYN;
            tx_seq   = ISS;
            tx_ack   = 32'd0;
            timer_d  = 32'd1;
          end else begin
            syn_pend_d = 1'b1;
          end
        end
      end

      ST_SYN_SENT: begin
        // The timer counts the SYN's own send cycle as its first tick
        if (!syn_pend_q && timer_q != SYN_TIMEOUT) begin
          timer_d = timer_q + 32'd1;
        end
        if (seg_valid) begin
          if (f_rst) begin
            if (tcp_ack_num_i == snd_nxt_q) begin
              state_d = ST_CLOSED;
              error_d = 1'b1;
            end
          end else if (f_syn && ack_ok) begin
            rcv_nxt_d = tcp_seq_num_i + 32'd1;
            tx_req    = 1'b1;
            tx_ack    = tcp_seq_num_i + 32'd1;
            state_d   = ST_ESTABLISHED;
          end else if (f_ack && !ack_ok) begin
            tx_req   = 1'b1;
            tx_flags = FLG_RST;
            tx_seq   = tcp_ack_num_i;
            tx_ack   = 32'd0;
          end
        end else if (syn_pend_q) begin
          if (can_tx) begin
            tx_req     = 1'b1;
            tx_flags   = FLG_SYN;
            tx_seq     = ISS;
            tx_ack     = 32'd0;
            syn_pend_d = 1'b0;
            timer_d    = 32'd1;
          end
        end else if (timer_q == SYN_TIMEOUT) begin
          if (retries_q < MAX_RETRIES) begin
            if (can_tx) begin
              tx_req    = 1'b1;
              tx_flags  = FLG_SYN;
              tx_seq    = ISS;
              tx_ack    = 32'd0;
              retries_d = retries_q + 8'd1;
              timer_d   = 32'd1;
            end
          end else begin
            state_d = ST_CLOSED;
            error_d = 1'b1;
          end
        end
      end

      ST_ESTABLISHED: begin
        if (seg_valid) begin
          if (f_rst) begin
            state_d = ST_CLOSED;
            error_d = 1'b1;
          end else if (in_order) begin
            // A bare in-order ACK is not itself acknowledged
            if (f_fin) begin
              rcv_nxt_d = rcv_adv;
              accept_d  = has_len;
              tx_req    = 1'b1;
              tx_flags  = FLG_FIN_ACK;
              tx_ack    = rcv_adv;
              snd_nxt_d = snd_nxt_q + 32'd1;
              state_d   = ST_LAST_ACK;
            end else if (has_len) begin
              rcv_nxt_d = rcv_adv;
              accept_d  = 1'b1;
              tx_req    = 1'b1;
              tx_ack    = rcv_adv;
            end
          end else if (has_len || f_fin) begin
            tx_req = 1'b1;
          end
        end else if (close_pend_q && can_tx) begin
          tx_req    = 1'b1;
          tx_flags  = FLG_FIN_ACK;
          snd_nxt_d = snd_nxt_q + 32'd1;
          state_d   = ST_FIN_WAIT1;
        end
      end

      ST_FIN_WAIT1, ST_FIN_WAIT2: begin
        if (seg_valid) begin
          if (f_rst) begin
            state_d = ST_CLOSED;
            error_d = 1'b1;
          end else begin
            if (in_order) begin
              rcv_nxt_d = rcv_adv;
              accept_d  = has_len;
            end
            if (in_order && f_fin) begin
              tx_req  = 1'b1;
              tx_ack  = rcv_adv;
              timer_d = 32'd0;
              state_d = ST_TIME_WAIT;
            end else begin
              if (state_q == ST_FIN_WAIT1 && ack_ok) begin
                state_d = ST_FIN_WAIT2;
              end
              if (in_order && has_len) begin
                tx_req = 1'b1;
                tx_ack = rcv_adv;
              end else if (!in_order && (has_len || f_fin)) begin
                tx_req = 1'b1;
              end
            end
          end
        end
      end

      ST_LAST_ACK: begin
        if (seg_valid) begin
          if (f_rst) begin
            state_d = ST_CLOSED;
            error_d = 1'b1;
          end else if (ack_ok) begin
            state_d = ST_CLOSED;
          end
        end
      end

      ST_TIME_WAIT: begin
        if (timer_q != TIME_WAIT_CYC) begin
          timer_d = timer_q + 32'd1;
        end
        if (seg_valid) begin
          if (f_rst) begin
            state_d = ST_CLOSED;
            error_d = 1'b1;
          end else if (f_fin) begin
            // The peer missed our ACK of its FIN: repeat it and wait out the full period again
            tx_req  = 1'b1;
            timer_d = 32'd0;
          end
        end else if (timer_q == TIME_WAIT_CYC) begin
          state_d = ST_CLOSED;
        end
      end

      default: begin
        state_d = ST_CLOSED;
      end
    endcase

    // A close request only survives while the connection stays established
    close_pend_d = (state_d == ST_ESTABLISHED) &&
                   (close_pend_q || (close_i && state_q == ST_ESTABLISHED));
  end

  // Transmit header fields are captured with the start pulse and held until the next one
  always_comb begin
    start_d    = tx_req;
    flags_d    = flags_q;
    seq_d      = seq_q;
    ack_d      = ack_q;
    head_len_d = head_len_q;
    if (tx_req) begin
      flags_d    = tx_flags;
      seq_d      = tx_seq;
      ack_d      = tx_ack;
      head_len_d = (tx_flags == FLG_SYN) ? 4'd8 : 4'd5;
    end
  end

  // State and output registers; reset drops any connection without signalling the peer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLOSED;
      snd_nxt_q    <= ISS;
      rcv_nxt_q    <= 32'd0;
      timer_q      <= 32'd0;
      retries_q    <= 8'd0;
      syn_pend_q   <= 1'b0;
      close_pend_q <= 1'b0;
      tx_busy_q    <= 1'b0;
      start_q      <= 1'b0;
      rd_q         <= 1'b0;
      accept_q     <= 1'b0;
      error_q      <= 1'b0;
      flags_q      <= 6'd0;
      seq_q        <= 32'd0;
      ack_q        <= 32'd0;
      head_len_q   <= 4'd5;
    end else begin
      state_q      <= state_d;
      snd_nxt_q    <= snd_nxt_d;
      rcv_nxt_q    <= rcv_nxt_d;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      syn_pend_q   <= syn_pend_d;
      close_pend_q <= close_pend_d;
      tx_busy_q    <= tx_busy_d;
      start_q      <= start_d;
      rd_q         <= rd_d;
      accept_q     <= accept_d;
      error_q      <= error_d;
      flags_q      <= flags_d;
      seq_q        <= seq_d;
      ack_q        <= ack_d;
      head_len_q   <= head_len_d;
    end
  end

  assign tcp_op_rcv_rd_o   = rd_q;
  assign tcp_source_port_o = LOCAL_PORT;
  assign tcp_dest_port_o   = REMOTE_PORT;
  assign tcp_flags_o       = flags_q;
  assign tcp_seq_num_o     = seq_q;
  assign tcp_ack_num_o     = ack_q;
  assign tcp_head_len_o    = head_len_q;
  assign tcp_data_len_o    = 16'd0;
  assign tcp_start_o       = start_q;
  assign rx_accept_o       = accept_q;
  assign connected_o       = (state_q == ST_ESTABLISHED);
  assign error_o           = error_q;

endmodule

// File: tb/tb_tcp_client_controller.sv
// Directed testbench for tcp_client_controller: handshake, data, both close
// directions, SYN give-up, RST and mid-connection reset.
module tb_tcp_client_controller;

   localparam logic [31:0] T_SYN = 32'd40;
   localparam logic [31:0] T_TW  = 32'd30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        open_i = 1'b0;
   logic        close_i = 1'b0;
   logic        tcp_op_rcv_i = 1'b0;
   logic [15:0] tcp_source_port_i = 16'd0;
   logic [5:0]  tcp_flags_i = 6'd0;
   logic [31:0] tcp_seq_num_i = 32'd0;
   logic [31:0] tcp_ack_num_i = 32'd0;
   logic [15:0] tcp_data_len_i = 16'd0;
   logic        tcp_op_rcv_rd_o;
   logic [15:0] tcp_source_port_o;
   logic [15:0] tcp_dest_port_o;
   logic [5:0]  tcp_flags_o;
   logic [31:0] tcp_seq_num_o;
   logic [31:0] tcp_ack_num_o;
   logic [3:0]  tcp_head_len_o;
   logic [15:0] tcp_data_len_o;
   logic        tcp_start_o;
   logic        tcp_write_op_end_i = 1'b0;
   logic        trnsmt_busy_i = 1'b0;
   logic        rx_accept_o;
   logic        connected_o;
   logic        error_o;

   int          assertCount = 0;
   int          failCount = 0;
   int          cycle = 0;
   int          txCount = 0;
   int          errCount = 0;
   int          wrCnt = 0;
   int          startCycles[$];
   int          errCycle = 0;
   logic [5:0]  lastFlags = 6'd0;
   logic [31:0] lastSeq = 32'd0;
   logic [31:0] lastAck = 32'd0;
   logic [3:0]  lastHl = 4'd0;
   logic        segAccept;
   logic        segError;

   tcp_client_controller #(
      .SYN_TIMEOUT  (T_SYN),
      .SYN_RETRIES  (3),
      .TIME_WAIT_CYC(T_TW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .open_i            (open_i),
      .close_i           (close_i),
      .tcp_op_rcv_i      (tcp_op_rcv_i),
      .tcp_source_port_i (tcp_source_port_i),
      .tcp_flags_i       (tcp_flags_i),
      .tcp_seq_num_i     (tcp_seq_num_i),
      .tcp_ack_num_i     (tcp_ack_num_i),
      .tcp_data_len_i    (tcp_data_len_i),
      .tcp_op_rcv_rd_o   (tcp_op_rcv_rd_o),
      .tcp_source_port_o (tcp_source_port_o),
      .tcp_dest_port_o   (tcp_dest_port_o),
      .tcp_flags_o       (tcp_flags_o),
      .tcp_seq_num_o     (tcp_seq_num_o),
      .tcp_ack_num_o     (tcp_ack_num_o),
      .tcp_head_len_o    (tcp_head_len_o),
      .tcp_data_len_o    (tcp_data_len_o),
      .tcp_start_o       (tcp_start_o),
      .tcp_write_op_end_i(tcp_write_op_end_i),
      .trnsmt_busy_i     (trnsmt_busy_i),
      .rx_accept_o       (rx_accept_o),
      .connected_o       (connected_o),
      .error_o           (error_o)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Free-running cycle index used to time retransmissions
   always @(posedge clk) cycle <= cycle + 1;

   // Header-writer model and tx/error monitor, sampled just after each rising edge
   always @(posedge clk) begin
      #1;
      tcp_write_op_end_i = 1'b0;
      if (wrCnt != 0) begin
         wrCnt = wrCnt - 1;
         if (wrCnt == 0) tcp_write_op_end_i = 1'b1;
      end
      if (tcp_start_o) begin
         txCount   = txCount + 1;
         lastFlags = tcp_flags_o;
         lastSeq   = tcp_seq_num_o;
         lastAck   = tcp_ack_num_o;
         lastHl    = tcp_head_len_o;
         startCycles.push_back(cycle);
         wrCnt     = 3;
      end
      if (error_o) begin
         errCount = errCount + 1;
         errCycle = cycle;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseOpen();
      @(negedge clk);
      open_i = 1'b1;
      @(negedge clk);
      open_i = 1'b0;
   endtask

   // Presents one rx header, waits (bounded) for the pop and samples the per-segment pulses
   task automatic applyStimulus(input logic [15:0] port, input logic [5:0] flags,
                                input logic [31:0] seq, input logic [31:0] ack,
                                input logic [15:0] len);
      logic popped;
      popped = 1'b0;
      segAccept = 1'b0;
      segError = 1'b0;
      @(negedge clk);
      tcp_source_port_i = port;
      tcp_flags_i       = flags;
      tcp_seq_num_i     = seq;
      tcp_ack_num_i     = ack;
      tcp_data_len_i    = len;
      tcp_op_rcv_i      = 1'b1;
      for (int i = 0; i < 50 && !popped; i++) begin
         @(negedge clk);
         if (tcp_op_rcv_rd_o) popped = 1'b1;
      end
      checkOutput("rx_pop", {31'd0, popped}, 32'd1);
      if (popped) begin
         @(negedge clk);
         segAccept = rx_accept_o;
         segError  = error_o;
      end
      tcp_op_rcv_i = 1'b0;
   endtask

   task automatic checkTx(input string tag, input int expCount, input logic [5:0] expFlags,
                          input logic [31:0] expSeq, input logic [31:0] expAck, input logic [3:0] expHl);
      checkOutput({tag, "_count"}, 32'(txCount), 32'(expCount));
      checkOutput({tag, "_flags"}, {26'd0, lastFlags}, {26'd0, expFlags});
      checkOutput({tag, "_seq"}, lastSeq, expSeq);
      checkOutput({tag, "_ack"}, lastAck, expAck);
      checkOutput({tag, "_hl"}, {28'd0, lastHl}, {28'd0, expHl});
   endtask

   initial begin
      int base;
      int idx;
      int errBefore;
      int gaps[4];

      // Reset values
      waitCycles(3);
      checkOutput("rst_start", {31'd0, tcp_start_o}, 32'd0);
      checkOutput("rst_rd", {31'd0, tcp_op_rcv_rd_o}, 32'd0);
      checkOutput("rst_flags", {26'd0, tcp_flags_o}, 32'd0);
      checkOutput("rst_seq", tcp_seq_num_o, 32'd0);
      checkOutput("rst_ack", tcp_ack_num_o, 32'd0);
      checkOutput("rst_hl", {28'd0, tcp_head_len_o}, 32'd5);
      checkOutput("rst_dlen", {16'd0, tcp_data_len_o}, 32'd0);
      checkOutput("rst_conn", {31'd0, connected_o}, 32'd0);
      checkOutput("rst_err", {31'd0, error_o}, 32'd0);
      checkOutput("rst_acc", {31'd0, rx_accept_o}, 32'd0);
      checkOutput("src_port", {16'd0, tcp_source_port_o}, 32'h0000F719);
      checkOutput("dst_port", {16'd0, tcp_dest_port_o}, 32'd5000);
      rst = 1'b0;
      $display("[TB] reset released");

      // Handshake
      pulseOpen();
      waitCycles(4);
      checkTx("syn", 1, 6'h02, 32'h0, 32'h0, 4'd8);
      applyStimulus(16'd5000, 6'h12, 32'h1000, 32'h1, 16'd0);
      waitCycles(4);
      checkTx("hs_ack", 2, 6'h10, 32'h1, 32'h1001, 4'd5);
      checkOutput("connected", {31'd0, connected_o}, 32'd1);

      // In-order data, out-of-order data, foreign port
      applyStimulus(16'd5000, 6'h18, 32'h1001, 32'h1, 16'd100);
      checkOutput("inorder_accept", {31'd0, segAccept}, 32'd1);
      waitCycles(4);
      checkTx("data_ack", 3, 6'h10, 32'h1, 32'h1065, 4'd5);
      applyStimulus(16'd5000, 6'h18, 32'h2000, 32'h1, 16'd100);
      checkOutput("ooo_accept", {31'd0, segAccept}, 32'd0);
      waitCycles(4);
      checkTx("dup_ack", 4, 6'h10, 32'h1, 32'h1065, 4'd5);
      applyStimulus(16'd1234, 6'h11, 32'h1065, 32'h1, 16'd0);
      waitCycles(4);
      checkOutput("wrong_port_tx", 32'(txCount), 32'd4);
      checkOutput("wrong_port_conn", {31'd0, connected_o}, 32'd1);

      // Active close through TIME_WAIT
      @(negedge clk);
      close_i = 1'b1;
      @(negedge clk);
      close_i = 1'b0;
      waitCycles(4);
      checkTx("close_fin", 5, 6'h11, 32'h1, 32'h1065, 4'd5);
      checkOutput("close_conn", {31'd0, connected_o}, 32'd0);
      applyStimulus(16'd5000, 6'h10, 32'h1065, 32'h2, 16'd0);
      waitCycles(4);
      checkOutput("fw1_ack_notx", 32'(txCount), 32'd5);
      applyStimulus(16'd5000, 6'h11, 32'h1065, 32'h2, 16'd0);
      waitCycles(4);
      checkTx("fw2_fin_ack", 6, 6'h10, 32'h2, 32'h1066, 4'd5);
      applyStimulus(16'd5000, 6'h11, 32'h1065, 32'h2, 16'd0);
      waitCycles(4);
      checkTx("tw_reack", 7, 6'h10, 32'h2, 32'h1066, 4'd5);
      pulseOpen();
      waitCycles(4);
      checkOutput("tw_open_ignored", 32'(txCount), 32'd7);
      waitCycles(40);
      pulseOpen();
      waitCycles(4);
      checkTx("reopen_syn", 8, 6'h02, 32'h0, 32'h0, 4'd8);

      // Bad ACK in SYN_SENT draws a RST, then the good SYN+ACK connects
      applyStimulus(16'd5000, 6'h12, 32'h1000, 32'h5, 16'd0);
      waitCycles(4);
      checkTx("synsent_rst", 9, 6'h04, 32'h5, 32'h0, 4'd5);
      checkOutput("synsent_notconn", {31'd0, connected_o}, 32'd0);
      applyStimulus(16'd5000, 6'h12, 32'h1000, 32'h1, 16'd0);
      waitCycles(4);
      checkTx("hs2_ack", 10, 6'h10, 32'h1, 32'h1001, 4'd5);

      // Passive close
      applyStimulus(16'd5000, 6'h11, 32'h1001, 32'h1, 16'd0);
      waitCycles(4);
      checkTx("peer_fin", 11, 6'h11, 32'h1, 32'h1002, 4'd5);
      checkOutput("lastack_conn", {31'd0, connected_o}, 32'd0);
      applyStimulus(16'd5000, 6'h10, 32'h1002, 32'h2, 16'd0);
      waitCycles(4);
      checkOutput("lastack_notx", 32'(txCount), 32'd11);

      // SYN retransmission and give-up
      idx = txCount;
      errBefore = errCount;
      pulseOpen();
      for (int i = 0; i < 400 && errCount == errBefore; i++) @(negedge clk);
      checkOutput("giveup_err", 32'(errCount - errBefore), 32'd1);
      checkOutput("giveup_syns", 32'(txCount - idx), 32'd4);
      checkOutput("giveup_conn", {31'd0, connected_o}, 32'd0);
      base = (startCycles.size() > idx) ? startCycles[idx] : 0;
      for (int k = 1; k < 4; k++) gaps[k] = (startCycles.size() > idx + k) ? startCycles[idx + k] - base : -1;
      checkOutput("syn_retx_1", 32'(gaps[1]), T_SYN);
      checkOutput("syn_retx_2", 32'(gaps[2]), 2 * T_SYN);
      checkOutput("syn_retx_3", 32'(gaps[3]), 3 * T_SYN);
      checkOutput("giveup_time", 32'(errCycle - base), 4 * T_SYN);

      // RST in ESTABLISHED
      pulseOpen();
      waitCycles(4);
      applyStimulus(16'd5000, 6'h12, 32'h1000, 32'h1, 16'd0);
      waitCycles(4);
      checkOutput("conn3", {31'd0, connected_o}, 32'd1);
      base = txCount;
      applyStimulus(16'd5000, 6'h04, 32'h1001, 32'h1, 16'd0);
      checkOutput("rst_seg_err", {31'd0, segError}, 32'd1);
      waitCycles(4);
      checkOutput("rst_seg_notx", 32'(txCount), 32'(base));
      checkOutput("rst_seg_conn", {31'd0, connected_o}, 32'd0);

      // Reset with an ACK in flight, then a fresh open
      pulseOpen();
      waitCycles(4);
      applyStimulus(16'd5000, 6'h12, 32'h1000, 32'h1, 16'd0);
      waitCycles(4);
      applyStimulus(16'd5000, 6'h18, 32'h1001, 32'h1, 16'd20);
      checkOutput("inflight_start", {31'd0, tcp_start_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_start", {31'd0, tcp_start_o}, 32'd0);
      checkOutput("midrst_flags", {26'd0, tcp_flags_o}, 32'd0);
      checkOutput("midrst_seq", tcp_seq_num_o, 32'd0);
      checkOutput("midrst_ack", tcp_ack_num_o, 32'd0);
      checkOutput("midrst_hl", {28'd0, tcp_head_len_o}, 32'd5);
      checkOutput("midrst_conn", {31'd0, connected_o}, 32'd0);
      checkOutput("midrst_acc", {31'd0, rx_accept_o}, 32'd0);
      rst = 1'b0;
      waitCycles(5);
      base = txCount;
      pulseOpen();
      waitCycles(4);
      checkTx("postrst_syn", base + 1, 6'h02, 32'h0, 32'h0, 4'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
